feature_stream_sink: RTL and testbench
======================================

// Module: feature_stream_sink
// PURPOSE
//  AXI4-Stream slave terminating the FAST/BRIEF feature stream (one feature per beat, tlast = end of frame).
//  Unpacks each beat into descriptor/x/y and stores it in a ping-pong feature RAM of MAX_CORNERS entries per bank.
//  Exposes the last complete frame to the matcher through a 1-cycle-latency random-access read port.
//  Applies backpressure (tready) only while a finished frame waits for the matcher to release the read bank.
// PARAMETERS
//  AXIS_WIDTH   280   beat width: [255:0] desc, [266:256] x, [277:267] y, [278] null flag, [279] reserved
//  DESC_WIDTH   256   BRIEF descriptor bits
//  COORD_WIDTH  11    x/y coordinate width
//  MAX_CORNERS  1000  entries per bank; CNT_W = $clog2(MAX_CORNERS+1), ADDR_W = $clog2(MAX_CORNERS)
// PORTS
//  clk             in   1            single clock
//  rst             in   1            asynchronous, active-high reset
//  s_axis_tdata    in   AXIS_WIDTH   feature beat
//  s_axis_tvalid   in   1            beat valid
//  s_axis_tlast    in   1            last beat of frame
//  s_axis_tready   out  1            sink ready
//  frame_ready     out  1            read bank holds a complete frame (level)
//  frame_count     out  CNT_W        features stored in read bank
//  frame_overflow  out  1            read-bank frame had beats dropped (count saturated)
//  rd_release      in   1            1-cycle pulse: matcher finished with read bank
//  rd_addr         in   ADDR_W       read index
//  rd_desc         out  DESC_WIDTH   descriptor at rd_addr (registered)
//  rd_x, rd_y      out  COORD_WIDTH  coordinates at rd_addr (registered)
//  rd_hit          out  1            registered: rd_addr < frame_count && frame_ready at request
// BEHAVIOUR
//  Reset: tready=1, frame_ready=0, frame_count=0, frame_overflow=0, rd_*=0, rd_hit=0, wr_bank=0, wr_cnt=0, state FILL.
//  Accept = tvalid & tready. Null beat (tdata[278]=1): not stored, wr_cnt unchanged; tlast still honoured.
//  FILL: accepted non-null beat with wr_cnt<MAX_CORNERS -> RAM[wr_bank][wr_cnt] <= {y,x,desc}, wr_cnt++.
//   wr_cnt==MAX_CORNERS -> beat dropped, ovf_pend<=1; stream still accepted (never stalls for overflow).
//  Frame end (accepted tlast): final count = wr_cnt + (this beat stored ? 1 : 0).
//   If frame_ready==0 or rd_release same cycle -> swap next cycle: rd_bank<=wr_bank, wr_bank flips,
//    frame_ready<=1, frame_count<=final count, frame_overflow<=ovf_pend|this-beat-dropped; wr_cnt, ovf_pend cleared.
//   Else -> state WAIT_REL, latch final count/overflow, tready<=0 (registered, deasserts cycle after tlast accept).
//  WAIT_REL: tready=0; on rd_release -> perform swap as above, frame_ready stays 1, tready<=1, state FILL.
//  rd_release in FILL with frame_ready=1 and no simultaneous tlast -> frame_ready<=0, frame_count<=0.
//  rd_release while frame_ready=0 ignored. Zero-feature frame (null+tlast) still swaps; frame_count=0.
//  Read port: rd_desc/x/y/hit valid exactly 1 cycle after rd_addr; reads of read bank never see writes (banks disjoint).
//  On a swap cycle, reads issued that cycle return old-bank data; matcher must not read after rd_release.
//  Reset mid-frame: partial frame discarded, all state as reset; no beat accepted while rst=1.
// STRUCTURE
//  fast_brief_pkg: field offsets (DESC_LSB=0, X_LSB=256, Y_LSB=267, NULL_BIT=278), widths, state enum {FILL, WAIT_REL}.
//  Sub-module feature_bank_ram: simple dual-port RAM, depth 2*MAX_CORNERS, width 278, addr={bank,index}, 1-cycle read.
//  Top: FSM, wr_cnt/ovf_pend counters, bank pointer, frame_* registers, rd_hit compare.
// TESTING
//  3 beats (x=1,2,3; last tlast) -> tready stays 1; frame_ready=1, frame_count=3; rd_addr=1 -> rd_x=2, rd_hit=1 next cycle.
//  Frame A (2 beats) complete, no release, frame B tlast -> tready=0 after B; pulse rd_release -> frame_count=B size, tready=1.
//  MAX_CORNERS=4, send 6 beats + tlast -> frame_count=4, frame_overflow=1, entries 0..3 = first four beats.
//  Single null beat with tlast -> frame_ready=1, frame_count=0; rd_addr=0 -> rd_hit=0.
//  rd_release in same cycle as tlast of next frame -> immediate swap, no tready drop, frame_ready stays 1.
//  Assert rst mid-frame after 2 beats -> frame_ready=0, frame_count=0; next 1-beat frame -> frame_count=1, bank 0 data.

Source files
------------

// File: rtl/fast_brief_pkg.sv
// rtl/fast_brief_pkg.sv - FAST/BRIEF feature beat layout and sink state encoding
package fast_brief_pkg;

  localparam int DESC_W   = 256;
  localparam int COORD_W  = 11;
  localparam int AXIS_W   = 280;
  localparam int DESC_LSB = 0;
  localparam int X_LSB    = 256;
  localparam int Y_LSB    = 267;
  localparam int NULL_BIT = 278;
  localparam int ENTRY_W  = DESC_W + 2 * COORD_W;

  typedef enum logic [0:0] {
    FILL     = 1'b0,
    WAIT_REL = 1'b1
  } state_e;

endpackage

// File: rtl/feature_bank_ram.sv
// rtl/feature_bank_ram.sv - simple dual-port feature RAM holding both ping-pong banks
module feature_bank_ram #(
  parameter int WIDTH = 278,
  parameter int DEPTH = 2000,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q, rdata_d;

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  // Out-of-range read indices return zero instead of an undefined entry.
  always_comb begin
    rdata_d = '0;
    if ({1'b0, raddr} < (AW + 1)'(DEPTH)) rdata_d = mem_q[raddr];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rdata_q <= '0;
    else     rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/feature_stream_sink.sv
// rtl/feature_stream_sink.sv - AXI4-Stream feature sink with ping-pong frame banks for the matcher
module feature_stream_sink
  import fast_brief_pkg::*;
#(
  parameter int AXIS_WIDTH  = 280,
  parameter int DESC_WIDTH  = 256,
  parameter int COORD_WIDTH = 11,
  parameter int MAX_CORNERS = 1000,
  parameter int CNT_W       = $clog2(MAX_CORNERS + 1),
  parameter int ADDR_W      = $clog2(MAX_CORNERS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [AXIS_WIDTH-1:0]  s_axis_tdata,
  input  logic                   s_axis_tvalid,
  input  logic                   s_axis_tlast,
  output logic                   s_axis_tready,
  output logic                   frame_ready,
  output logic [CNT_W-1:0]       frame_count,
  output logic                   frame_overflow,
  input  logic                   rd_release,
  input  logic [ADDR_W-1:0]      rd_addr,
  output logic [DESC_WIDTH-1:0]  rd_desc,
  output logic [COORD_WIDTH-1:0] rd_x,
  output logic [COORD_WIDTH-1:0] rd_y,
  output logic                   rd_hit
);

  localparam int ENTRY_WIDTH = DESC_WIDTH + 2 * COORD_WIDTH;
  localparam int RAM_DEPTH   = 2 * MAX_CORNERS;
  localparam int RAM_AW      = $clog2(RAM_DEPTH);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] wr_cnt_q, wr_cnt_d;
  logic [CNT_W-1:0] frame_count_q, frame_count_d;
  logic             ovf_pend_q, ovf_pend_d;
  logic             wr_bank_q, wr_bank_d;
  logic             rd_bank_q, rd_bank_d;
  logic             tready_q, tready_d;
  logic             frame_ready_q, frame_ready_d;
  logic             frame_overflow_q, frame_overflow_d;
  logic             rd_hit_q, rd_hit_d;

  logic             accept, is_null, store, drop, frame_end;
  logic [CNT_W-1:0] final_cnt;
  logic             final_ovf;

  logic                   ram_we;
  logic [RAM_AW-1:0]      ram_waddr, ram_raddr;
  logic [ENTRY_WIDTH-1:0] ram_wdata, ram_rdata;
  logic                   unused_reserved;

  assign unused_reserved = s_axis_tdata[AXIS_WIDTH-1];

  assign accept    = s_axis_tvalid & tready_q;
  assign is_null   = s_axis_tdata[NULL_BIT];
  assign store     = accept & ~is_null & (wr_cnt_q < CNT_W'(MAX_CORNERS));
  assign drop      = accept & ~is_null & (wr_cnt_q == CNT_W'(MAX_CORNERS));
  assign frame_end = accept & s_axis_tlast;
  assign final_cnt = wr_cnt_q + CNT_W'(store);
  assign final_ovf = ovf_pend_q | drop;

  always_comb begin
    state_d          = state_q;
    wr_cnt_d         = wr_cnt_q;
    ovf_pend_d       = ovf_pend_q;
    wr_bank_d        = wr_bank_q;
    rd_bank_d        = rd_bank_q;
    tready_d         = tready_q;
    frame_ready_d    = frame_ready_q;
    frame_count_d    = frame_count_q;
    frame_overflow_d = frame_overflow_q;

    if (store) wr_cnt_d = final_cnt;
    if (drop)  ovf_pend_d = 1'b1;

    case (state_q)
      FILL: begin
        if (frame_end) begin
          if (!frame_ready_q || rd_release) begin
            rd_bank_d        = wr_bank_q;
            wr_bank_d        = ~wr_bank_q;
            frame_ready_d    = 1'b1;
            frame_count_d    = final_cnt;
            frame_overflow_d = final_ovf;
            wr_cnt_d         = '0;
            ovf_pend_d       = 1'b0;
          end else begin
            // wr_cnt/ovf_pend hold the finished frame's totals while stalled.
            state_d  = WAIT_REL;
            tready_d = 1'b0;
          end
        end else if (rd_release && frame_ready_q) begin
          frame_ready_d    = 1'b0;
          frame_count_d    = '0;
          frame_overflow_d = 1'b0;
        end
      end
      WAIT_REL: begin
        if (rd_release) begin
          rd_bank_d        = wr_bank_q;
          wr_bank_d        = ~wr_bank_q;
          frame_count_d    = wr_cnt_q;
          frame_overflow_d = ovf_pend_q;
          wr_cnt_d         = '0;
          ovf_pend_d       = 1'b0;
          tready_d         = 1'b1;
          state_d          = FILL;
        end
      end
      default: state_d = FILL;
    endcase
  end

  assign rd_hit_d = frame_ready_q && (CNT_W'(rd_addr) < frame_count_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= FILL;
      wr_cnt_q         <= '0;
      ovf_pend_q       <= 1'b0;
      wr_bank_q        <= 1'b0;
      rd_bank_q        <= 1'b0;
      tready_q         <= 1'b1;
      frame_ready_q    <= 1'b0;
      frame_count_q    <= '0;
      frame_overflow_q <= 1'b0;
      rd_hit_q         <= 1'b0;
    end else begin
      state_q          <= state_d;
      wr_cnt_q         <= wr_cnt_d;
      ovf_pend_q       <= ovf_pend_d;
      wr_bank_q        <= wr_bank_d;
      rd_bank_q        <= rd_bank_d;
      tready_q         <= tready_d;
      frame_ready_q    <= frame_ready_d;
      frame_count_q    <= frame_count_d;
      frame_overflow_q <= frame_overflow_d;
      rd_hit_q         <= rd_hit_d;
    end
  end

  // Bank 1 occupies the upper MAX_CORNERS entries of the shared RAM.
  assign ram_we    = store & ~rst;
  assign ram_waddr = (wr_bank_q ? RAM_AW'(MAX_CORNERS) : '0) + RAM_AW'(wr_cnt_q);
  assign ram_raddr = (rd_bank_q ? RAM_AW'(MAX_CORNERS) : '0) + RAM_AW'(rd_addr);
  assign ram_wdata = {s_axis_tdata[Y_LSB +: COORD_WIDTH],
                      s_axis_tdata[X_LSB +: COORD_WIDTH],
                      s_axis_tdata[DESC_LSB +: DESC_WIDTH]};

  feature_bank_ram #(
    .WIDTH (ENTRY_WIDTH),
    .DEPTH (RAM_DEPTH),
    .AW    (RAM_AW)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .raddr (ram_raddr),
    .rdata (ram_rdata)
  );

  assign s_axis_tready  = tready_q;
  assign frame_ready    = frame_ready_q;
  assign frame_count    = frame_count_q;
  assign frame_overflow = frame_overflow_q;
  assign rd_desc        = ram_rdata[0 +: DESC_WIDTH];
  assign rd_x           = ram_rdata[DESC_WIDTH +: COORD_WIDTH];
  assign rd_y           = ram_rdata[DESC_WIDTH + COORD_WIDTH +: COORD_WIDTH];
  assign rd_hit         = rd_hit_q;

endmodule

// File: tb/tb_feature_stream_sink.sv
// tb/tb_feature_stream_sink.sv - directed self-checking bench for feature_stream_sink
module tb_feature_stream_sink;

  localparam int MC = 4;
  localparam int CW = 3;
  localparam int AW = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic [279:0]   s_axis_tdata;
  logic           s_axis_tvalid, s_axis_tlast, s_axis_tready;
  logic           frame_ready, frame_overflow, rd_release, rd_hit;
  logic [CW-1:0]  frame_count;
  logic [AW-1:0]  rd_addr;
  logic [255:0]   rd_desc;
  logic [10:0]    rd_x, rd_y;

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  feature_stream_sink #(.MAX_CORNERS(MC)) dut (
    .clk            (clk),
    .rst            (rst),
    .s_axis_tdata   (s_axis_tdata),
    .s_axis_tvalid  (s_axis_tvalid),
    .s_axis_tlast   (s_axis_tlast),
    .s_axis_tready  (s_axis_tready),
    .frame_ready    (frame_ready),
    .frame_count    (frame_count),
    .frame_overflow (frame_overflow),
    .rd_release     (rd_release),
    .rd_addr        (rd_addr),
    .rd_desc        (rd_desc),
    .rd_x           (rd_x),
    .rd_y           (rd_y),
    .rd_hit         (rd_hit)
  );

  function automatic logic [255:0] desc_of(input logic [10:0] x);
    return {16{5'b0, x}};
  endfunction

  function automatic logic [10:0] y_of(input logic [10:0] x);
    return x + 11'd100;
  endfunction

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic beat(input logic [10:0] x, input logic nul, input logic last, input logic rel);
    s_axis_tdata  = {1'b0, nul, y_of(x), x, desc_of(x)};
    s_axis_tvalid = 1'b1;
    s_axis_tlast  = last;
    rd_release    = rel;
    @(posedge clk); #1;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    rd_release    = 1'b0;
    s_axis_tdata  = '0;
  endtask

  task automatic release_pulse();
    rd_release = 1'b1;
    @(posedge clk); #1;
    rd_release = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [AW-1:0] a, input logic [10:0] ex, input logic eh);
    rd_addr = a;
    @(posedge clk); #1;
    chk({tag, "_hit"}, 256'(rd_hit), 256'(eh));
    if (eh) begin
      chk({tag, "_x"}, 256'(rd_x), 256'(ex));
      chk({tag, "_y"}, 256'(rd_y), 256'(y_of(ex)));
      chk({tag, "_desc"}, rd_desc, desc_of(ex));
    end
  endtask

  initial begin
    rst = 1'b1;
    s_axis_tdata = '0; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
    rd_release = 1'b0; rd_addr = '0;
    repeat (2) @(posedge clk); #1;
    chk("rst_tready", 256'(s_axis_tready), 256'(1));
    chk("rst_frame_ready", 256'(frame_ready), 256'(0));
    chk("rst_frame_count", 256'(frame_count), 256'(0));
    chk("rst_overflow", 256'(frame_overflow), 256'(0));
    chk("rst_rd_hit", 256'(rd_hit), 256'(0));
    chk("rst_rd_x", 256'(rd_x), 256'(0));
    rst = 1'b0;
    @(posedge clk); #1;

    // Basic 3-beat frame into bank 0
    beat(11'd1, 1'b0, 1'b0, 1'b0);
    chk("f1_tready_b1", 256'(s_axis_tready), 256'(1));
    beat(11'd2, 1'b0, 1'b0, 1'b0);
    beat(11'd3, 1'b0, 1'b1, 1'b0);
    chk("f1_tready_end", 256'(s_axis_tready), 256'(1));
    chk("f1_frame_ready", 256'(frame_ready), 256'(1));
    chk("f1_frame_count", 256'(frame_count), 256'(3));
    chk("f1_overflow", 256'(frame_overflow), 256'(0));
    rd_chk("f1_rd1", 2'd1, 11'd2, 1'b1);
    rd_chk("f1_rd3", 2'd3, 11'd0, 1'b0);

    // Release, then frame A completes; frame B stalls until released
    release_pulse();
    chk("rel_frame_ready", 256'(frame_ready), 256'(0));
    chk("rel_frame_count", 256'(frame_count), 256'(0));
    beat(11'd5, 1'b0, 1'b0, 1'b0);
    beat(11'd6, 1'b0, 1'b1, 1'b0);
    chk("fa_frame_count", 256'(frame_count), 256'(2));
    beat(11'd7, 1'b0, 1'b0, 1'b0);
    beat(11'd8, 1'b0, 1'b0, 1'b0);
    chk("fb_tready_mid", 256'(s_axis_tready), 256'(1));
    beat(11'd9, 1'b0, 1'b1, 1'b0);
    chk("fb_tready_stall", 256'(s_axis_tready), 256'(0));
    chk("fb_count_held", 256'(frame_count), 256'(2));
    rd_chk("fa_rd0", 2'd0, 11'd5, 1'b1);
    chk("fb_tready_still", 256'(s_axis_tready), 256'(0));
    release_pulse();
    chk("fb_frame_count", 256'(frame_count), 256'(3));
    chk("fb_tready_back", 256'(s_axis_tready), 256'(1));
    chk("fb_frame_ready", 256'(frame_ready), 256'(1));
    rd_chk("fb_rd2", 2'd2, 11'd9, 1'b1);

    // Release coincident with tlast swaps immediately
    beat(11'd11, 1'b0, 1'b0, 1'b0);
    beat(11'd12, 1'b0, 1'b1, 1'b1);
    chk("fc_tready", 256'(s_axis_tready), 256'(1));
    chk("fc_frame_ready", 256'(frame_ready), 256'(1));
    chk("fc_frame_count", 256'(frame_count), 256'(2));
    rd_chk("fc_rd1", 2'd1, 11'd12, 1'b1);

    // Overflow: 6 beats into a 4-entry bank
    release_pulse();
    for (int i = 0; i < 6; i++) begin
      beat(11'(20 + i), 1'b0, (i == 5), 1'b0);
      chk("ov_tready", 256'(s_axis_tready), 256'(1));
    end
    chk("ov_frame_count", 256'(frame_count), 256'(4));
    chk("ov_overflow", 256'(frame_overflow), 256'(1));
    for (int i = 0; i < 4; i++) rd_chk("ov_rd", 2'(i), 11'(20 + i), 1'b1);

    // Zero-feature frame
    release_pulse();
    beat(11'd0, 1'b1, 1'b1, 1'b0);
    chk("nul_frame_ready", 256'(frame_ready), 256'(1));
    chk("nul_frame_count", 256'(frame_count), 256'(0));
    chk("nul_overflow", 256'(frame_overflow), 256'(0));
    rd_chk("nul_rd0", 2'd0, 11'd0, 1'b0);

    // Reset mid-frame discards the partial frame
    beat(11'd30, 1'b0, 1'b0, 1'b0);
    beat(11'd31, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mr_frame_ready", 256'(frame_ready), 256'(0));
    chk("mr_frame_count", 256'(frame_count), 256'(0));
    chk("mr_tready", 256'(s_axis_tready), 256'(1));
    beat(11'd40, 1'b0, 1'b1, 1'b0);
    chk("mr_new_count", 256'(frame_count), 256'(1));
    rd_chk("mr_rd0", 2'd0, 11'd40, 1'b1);
    rd_chk("mr_rd1", 2'd1, 11'd0, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
